// File: rtl/ook_packet_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ook_packet_ctrl: OOK frame sequencer (preamble, start, 8 data, gap)      |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module ook_packet_ctrl #(
   parameter int SYM_DIV  = 1000,
   parameter int PRE_BITS = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tx_valid,
   input  logic [7:0] tx_data,
   output logic       tx_ready,
   input  logic       abort,
   output logic       ook_data,
   output logic       phase_clr,
   output logic       busy,
   output logic       done
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      PREAMBLE = 3'd1,
      START    = 3'd2,
      DATA     = 3'd3,
      GAP      = 3'd4
   } state_t;

   localparam logic [15:0] SYM_LAST = 16'(SYM_DIV - 1);
   localparam logic [4:0]  PRE_LAST = 5'(PRE_BITS - 1);

   state_t      state;
   logic [15:0] sym_cnt;
   logic [4:0]  bit_cnt;
   logic [7:0]  shreg;

   assign tx_ready = (state == IDLE) && !rst;
   assign busy     = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         sym_cnt   <= '0;
         bit_cnt   <= '0;
         shreg     <= '0;
         ook_data  <= 1'b0;
         phase_clr <= 1'b0;
         done      <= 1'b0;
      end else begin
         phase_clr <= 1'b0;
         done      <= 1'b0;
         if (state == IDLE) begin
            if (tx_valid) begin
               state     <= PREAMBLE;
               shreg     <= tx_data;
               sym_cnt   <= '0;
               bit_cnt   <= '0;
               ook_data  <= 1'b1;
               phase_clr <= 1'b1;
            end
         end else if (abort) begin
            state    <= IDLE;
            sym_cnt  <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            ook_data <= 1'b0;
         end else if (sym_cnt == SYM_LAST) begin
            // Symbol boundary: ook_data takes the value of the symbol about to start.
            sym_cnt <= '0;
            case (state)
               PREAMBLE: begin
                  if (bit_cnt == PRE_LAST) begin
                     state    <= START;
                     bit_cnt  <= '0;
                     ook_data <= 1'b1;
                  end else begin
                     bit_cnt  <= bit_cnt + 5'd1;
                     ook_data <= bit_cnt[0];
                  end
               end
               START: begin
                  state    <= DATA;
                  bit_cnt  <= '0;
                  ook_data <= shreg[7];
               end
               DATA: begin
                  if (bit_cnt == 5'd7) begin
                     state    <= GAP;
                     bit_cnt  <= '0;
                     ook_data <= 1'b0;
                  end else begin
                     bit_cnt  <= bit_cnt + 5'd1;
                     ook_data <= shreg[6];
                     shreg    <= {shreg[6:0], 1'b0};
                  end
               end
               GAP: begin
                  ook_data <= 1'b0;
                  if (bit_cnt == 5'd1) begin
                     state   <= IDLE;
                     bit_cnt <= '0;
                     done    <= 1'b1;
                  end else begin
                     bit_cnt <= bit_cnt + 5'd1;
                  end
               end
               default: begin
                  state    <= IDLE;
                  bit_cnt  <= '0;
                  ook_data <= 1'b0;
               end
            endcase
         end else begin
            sym_cnt <= sym_cnt + 16'd1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ook_packet_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ook_packet_ctrl: directed and random checks against a frame model     |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_ook_packet_ctrl;

   localparam int SYM_DIV   = 4;
   localparam int PRE_BITS  = 4;
   localparam int FRAME_LEN = (PRE_BITS + 11) * SYM_DIV;

   logic       clk = 1'b0;
   logic       rst;
   logic       tx_valid;
   logic [7:0] tx_data;
   logic       tx_ready;
   logic       abort;
   logic       ook_data;
   logic       phase_clr;
   logic       busy;
   logic       done;

   int n_checks = 0;
   int n_fail   = 0;

   ook_packet_ctrl #(.SYM_DIV(SYM_DIV), .PRE_BITS(PRE_BITS)) dut (
      .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_data(tx_data),
      .tx_ready(tx_ready), .abort(abort), .ook_data(ook_data),
      .phase_clr(phase_clr), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Value of symbol s within a frame carrying byte b.
   function automatic logic sym_val(input logic [7:0] b, input int s);
      if (s < PRE_BITS) return (s % 2 == 0);
      if (s == PRE_BITS) return 1'b1;
      if (s < PRE_BITS + 9) return b[7 - (s - PRE_BITS - 1)];
      return 1'b0;
   endfunction

   // Frame model: position within the frame, advanced once per clock.
   bit         m_active = 1'b0;
   int         m_t      = 0;
   logic [7:0] m_byte   = 8'h00;
   bit         m_done   = 1'b0;
   bit         started  = 1'b0;

   always @(posedge clk) begin
      m_done = 1'b0;
      if (rst) m_active = 1'b0;
      else if (!m_active) begin
         if (tx_valid) begin
            m_active = 1'b1;
            m_t      = 1;
            m_byte   = tx_data;
         end
      end else if (abort) m_active = 1'b0;
      else if (m_t == FRAME_LEN) begin
         m_active = 1'b0;
         m_done   = 1'b1;
      end else m_t++;
      started = 1'b1;
   end

   always @(negedge clk) begin
      if (started) begin
         chk("busy", 32'(busy), 32'(m_active));
         chk("ook_data", 32'(ook_data), 32'(m_active ? sym_val(m_byte, (m_t - 1) / SYM_DIV) : 1'b0));
         chk("phase_clr", 32'(phase_clr), 32'(m_active && m_t == 1));
         chk("done", 32'(done), 32'(m_done));
         chk("tx_ready", 32'(tx_ready), 32'(!m_active && !rst));
      end
   end

   logic ook_arr  [0:130];
   logic done_arr [0:130];
   logic pc_arr   [0:130];
   logic busy_arr [0:130];
   logic rdy_arr  [0:130];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      tx_valid = 1'b1;
      tx_data  = b;
      tick();
      tx_valid = 1'b0;
   endtask

   // Records cycles 1..n after an accept; optional one-cycle stray offer and tx_valid drop.
   task automatic collect(input int n, input int pulse_c, input int drop_c);
      for (int c = 1; c <= n; c++) begin
         if (pulse_c != 0 && c == pulse_c) begin
            tx_valid = 1'b1;
            tx_data  = 8'h00;
         end else if (pulse_c != 0 && c == pulse_c + 1) tx_valid = 1'b0;
         if (c == drop_c) tx_valid = 1'b0;
         @(negedge clk);
         ook_arr[c]  = ook_data;
         done_arr[c] = done;
         pc_arr[c]   = phase_clr;
         busy_arr[c] = busy;
         rdy_arr[c]  = tx_ready;
         tick();
      end
   endtask

   function automatic logic [7:0] data_at(input int base);
      logic [7:0] r;
      for (int s = 0; s < 8; s++) r[7 - s] = ook_arr[base + (PRE_BITS + 1 + s) * SYM_DIV];
      return r;
   endfunction

   initial begin
      logic [14:0] seq;
      int          ndone;
      int          nbusy;
      rst = 1'b1; tx_valid = 1'b0; tx_data = 8'h00; abort = 1'b0;
      repeat (3) tick();
      @(negedge clk);
      chk("reset tx_ready", 32'(tx_ready), 32'd0);
      chk("reset busy", 32'(busy), 32'd0);
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("post-reset tx_ready", 32'(tx_ready), 32'd1);
      tick();

      // 0xA5 frame, symbol sequence pinned by hand
      send(8'hA5);
      collect(62, 0, 0);
      for (int s = 0; s < 15; s++) seq[14 - s] = ook_arr[1 + s * SYM_DIV];
      chk("A5 symbols", 32'(seq), 32'(15'b1010_1_10100101_00));
      chk("A5 phase_clr c1", 32'(pc_arr[1]), 32'd1);
      chk("A5 phase_clr c2", 32'(pc_arr[2]), 32'd0);
      chk("A5 done c61", 32'(done_arr[61]), 32'd1);
      ndone = 0; nbusy = 0;
      for (int c = 1; c <= 62; c++) begin
         ndone += int'(done_arr[c]);
         nbusy += int'(busy_arr[c]);
      end
      chk("A5 done count", 32'(ndone), 32'd1);
      chk("A5 busy cycles", 32'(nbusy), 32'd60);

      // back-to-back 0xFF then 0x00 with tx_valid held
      tx_valid = 1'b1;
      tx_data  = 8'hFF;
      tick();
      tx_data = 8'h00;
      collect(124, 0, 62);
      chk("b2b done c61", 32'(done_arr[61]), 32'd1);
      chk("b2b ready c61", 32'(rdy_arr[61]), 32'd1);
      chk("b2b phase_clr c62", 32'(pc_arr[62]), 32'd1);
      chk("b2b frame1 data", 32'(data_at(1)), 32'hFF);
      chk("b2b frame2 data", 32'(data_at(62)), 32'h00);
      chk("b2b done c122", 32'(done_arr[122]), 32'd1);
      chk("b2b busy c123", 32'(busy_arr[123]), 32'd0);

      // abort at cycle 30
      send(8'hA5);
      repeat (29) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      @(negedge clk);
      chk("abort busy", 32'(busy), 32'd0);
      chk("abort ook", 32'(ook_data), 32'd0);
      chk("abort ready", 32'(tx_ready), 32'd1);
      chk("abort done", 32'(done), 32'd0);
      tick();
      collect(3, 0, 0);
      chk("abort no late done", 32'({done_arr[1], done_arr[2], done_arr[3]}), 32'd0);

      // reset at cycle 20, then a full frame
      send(8'hC3);
      repeat (19) tick();
      rst = 1'b1;
      tick();
      @(negedge clk);
      chk("rst ready", 32'(tx_ready), 32'd0);
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst ook", 32'(ook_data), 32'd0);
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("after rst ready", 32'(tx_ready), 32'd1);
      tick();
      send(8'h96);
      collect(61, 0, 0);
      chk("post-rst frame data", 32'(data_at(1)), 32'h96);
      chk("post-rst done c61", 32'(done_arr[61]), 32'd1);

      // tx_data changed and tx_valid pulsed mid-frame
      send(8'h3C);
      collect(63, 10, 0);
      chk("3C data", 32'(data_at(1)), 32'h3C);
      chk("3C done c61", 32'(done_arr[61]), 32'd1);
      chk("3C no second frame", 32'({busy_arr[62], busy_arr[63]}), 32'd0);

      // abort held in IDLE together with tx_valid
      abort    = 1'b1;
      tx_valid = 1'b1;
      tx_data  = 8'h5A;
      tick();
      tx_valid = 1'b0;
      @(negedge clk);
      chk("idle-abort accept busy", 32'(busy), 32'd1);
      chk("idle-abort phase_clr", 32'(phase_clr), 32'd1);
      tick();
      @(negedge clk);
      chk("idle-abort end busy", 32'(busy), 32'd0);
      chk("idle-abort end done", 32'(done), 32'd0);
      tick();
      abort = 1'b0;
      tick();

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         tx_valid = ($urandom_range(0, 3) == 0);
         tx_data  = 8'($urandom);
         abort    = ($urandom_range(0, 99) == 0);
         rst      = ($urandom_range(0, 599) == 0);
         tick();
      end
      tx_valid = 1'b0;
      abort    = 1'b0;
      rst      = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
